// File: rtl/morse_keyer.sv
// Morse keyer: queued dot/dash/gap symbols become a timed key waveform; key rises one edge after a symbol
// is accepted into an empty, idle queue. sym_ready is high while the FIFO is not full, and no symbol is dropped.
module morse_keyer #(
  parameter int UNIT_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       sym_ready,
  output logic       key,
  output logic       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(7 * UNIT_CYCLES);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  localparam logic [1:0] SYM_DOT    = 2'b00;
  localparam logic [1:0] SYM_DASH   = 2'b01;
  localparam logic [1:0] SYM_LETTER = 2'b10;
  localparam logic [1:0] SYM_WORD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  logic [1:0]    fifo_dat [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [1:0]    head_dat;
  logic          fifo_empty;
  logic          push_vld;
  logic          pop_vld;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          phase_end;

  function automatic logic [TW-1:0] units(input int n);
    units = TW'(n * UNIT_CYCLES - 1);
  endfunction

  assign fifo_empty = (count == '0);
  assign sym_ready  = (count != FULL_COUNT);
  assign push_vld   = sym_valid && sym_ready;
  assign head_dat   = fifo_dat[rd_ptr];
  assign phase_end  = (timer == '0);
  assign busy       = (state != IDLE) || !fifo_empty;

  // A new symbol is taken either from idle or on the exact edge a space ends,
  // so consecutive elements chain with no dead cycle.
  assign pop_vld = !fifo_empty &&
                   ((state == IDLE) || ((state == SPACE) && phase_end));

  always_ff @(posedge Clock) begin
    if (push_vld) begin
      fifo_dat[wr_ptr] <= sym;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_vld) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_vld, pop_vld})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        timer_nxt = '0;
      end
      MARK: begin
        if (phase_end) begin
          state_nxt = SPACE;
          timer_nxt = units(1);
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      SPACE: begin
        if (phase_end) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    // Gaps are 2 or 6 units here because the preceding element space
    // already supplied the first unit of the 3- or 7-unit total.
    if (pop_vld) begin
      case (head_dat)
        SYM_DOT: begin
          state_nxt = MARK;
          timer_nxt = units(1);
        end
        SYM_DASH: begin
          state_nxt = MARK;
          timer_nxt = units(3);
        end
        SYM_LETTER: begin
          state_nxt = SPACE;
          timer_nxt = units(2);
        end
        SYM_WORD: begin
          state_nxt = SPACE;
          timer_nxt = units(6);
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      timer <= '0;
      key   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      key   <= (state_nxt == MARK);
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer at UNIT_CYCLES=4, DEPTH=4; outputs are sampled on the falling edge.
module tb_morse_keyer;

  logic       Clock;
  logic       Reset;
  logic       sym_valid;
  logic [1:0] sym;
  logic       sym_ready;
  logic       key;
  logic       busy;

  int nvec;
  int nerr;

  morse_keyer #(.UNIT_CYCLES(4), .DEPTH(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_ready (sym_ready),
    .key       (key),
    .busy      (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Called 1ns after a rising edge; returns 1ns after the edge that accepted s.
  task automatic push(input logic [1:0] s);
    sym_valid = 1'b1;
    sym       = s;
    @(posedge Clock);
    #1;
    sym_valid = 1'b0;
    sym       = 2'b00;
  endtask

  task automatic test_reset;
    logic [11:0] ktr;
    logic [11:0] btr;
    Reset = 1'b0;
    sym_valid = 1'b0;
    sym = 2'b00;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    nvec++;
    if (key !== 1'b0) begin nerr++; $display("FAIL reset_key: got %b want 0", key); end
    nvec++;
    if (sym_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", sym_ready); end
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    Reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      ktr[i] = key;
      btr[i] = busy;
    end
    nvec++;
    if (ktr !== 12'h000) begin nerr++; $display("FAIL reset_idle_key: got %h want 000", ktr); end
    nvec++;
    if (btr !== 12'h000) begin nerr++; $display("FAIL reset_idle_busy: got %h want 000", btr); end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_single_dot;
    logic [11:0] ktr;
    logic [11:0] btr;
    push(2'b00);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      ktr[i] = key;
      btr[i] = busy;
    end
    nvec++;
    if (ktr !== 12'h01E) begin nerr++; $display("FAIL dot_key: got %h want 01e", ktr); end
    nvec++;
    if (btr !== 12'h1FF) begin nerr++; $display("FAIL dot_busy: got %h want 1ff", btr); end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [27:0] ktr;
    logic [27:0] btr;
    push(2'b01);
    push(2'b00);
    for (int i = 0; i < 28; i++) begin
      @(negedge Clock);
      ktr[i] = key;
      btr[i] = busy;
    end
    nvec++;
    if (ktr !== 28'h00F0FFF) begin nerr++; $display("FAIL dash_dot_key: got %h want 00f0fff", ktr); end
    nvec++;
    if (btr !== 28'h0FFFFFF) begin nerr++; $display("FAIL dash_dot_busy: got %h want 0ffffff", btr); end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_fifo_full;
    logic [10:0] rtr;
    int acc;
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      sym_valid = (i < 6);
      sym = 2'b00;
      @(negedge Clock);
      rtr[i] = sym_ready;
      if (sym_valid && sym_ready) acc++;
      @(posedge Clock);
      #1;
    end
    sym_valid = 1'b0;
    nvec++;
    if (acc !== 5) begin nerr++; $display("FAIL full_accepted: got %0d want 5", acc); end
    nvec++;
    if (rtr !== 11'h41F) begin nerr++; $display("FAIL full_ready_trace: got %h want 41f", rtr); end
    for (int c = 0; c < 200 && busy; c++) @(negedge Clock);
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL full_drain: busy got %b want 0", busy); end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_gaps;
    logic [23:0] ltr;
    logic [39:0] wtr;
    logic [11:0] gk;
    logic [11:0] gb;
    push(2'b00);
    push(2'b10);
    push(2'b00);
    for (int i = 0; i < 24; i++) begin
      @(negedge Clock);
      ltr[i] = key;
    end
    nvec++;
    if (ltr !== 24'h078007) begin nerr++; $display("FAIL letter_gap_key: got %h want 078007", ltr); end
    @(posedge Clock);
    #1;
    push(2'b00);
    push(2'b11);
    push(2'b00);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      wtr[i] = key;
    end
    nvec++;
    if (wtr !== 40'h0780000007) begin nerr++; $display("FAIL word_gap_key: got %h want 0780000007", wtr); end
    @(posedge Clock);
    #1;
    push(2'b10);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      gk[i] = key;
      gb[i] = busy;
    end
    nvec++;
    if (gk !== 12'h000) begin nerr++; $display("FAIL lead_gap_key: got %h want 000", gk); end
    nvec++;
    if (gb !== 12'h1FF) begin nerr++; $display("FAIL lead_gap_busy: got %h want 1ff", gb); end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset_mid_dash;
    logic [7:0] itr;
    logic [9:0] dtr;
    push(2'b01);
    push(2'b00);
    repeat (6) @(negedge Clock);
    nvec++;
    if (key !== 1'b1) begin nerr++; $display("FAIL mid_dash_key: got %b want 1", key); end
    #1;
    Reset = 1'b0;
    #1;
    nvec++;
    if (key !== 1'b0) begin nerr++; $display("FAIL async_reset_key: got %b want 0", key); end
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    nvec++;
    if (sym_ready !== 1'b1) begin nerr++; $display("FAIL async_reset_ready: got %b want 1", sym_ready); end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      itr[i] = key | busy;
    end
    nvec++;
    if (itr !== 8'h00) begin nerr++; $display("FAIL post_reset_discard: got %h want 00", itr); end
    @(posedge Clock);
    #1;
    push(2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      dtr[i] = key;
    end
    nvec++;
    if (dtr !== 10'h01E) begin nerr++; $display("FAIL post_reset_dot: got %h want 01e", dtr); end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_single_dot();
    test_back_to_back();
    test_fifo_full();
    test_gaps();
    test_reset_mid_dash();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
